// File: rtl/sigma_mem_responder_pkg.sv
// sigma_mem_responder_pkg: shared bus widths and FSM state encoding for the Sigma memory responder
package sigma_mem_responder_pkg;
  localparam int SIGMA_ADDR_W = 17;
  localparam int SIGMA_WORD_W = 32;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_ACK = 2'd2} state_e;
endpackage

// File: rtl/sigma_ram_sp.sv
// sigma_ram_sp: single-port synchronous RAM, one write or one registered read per enabled edge
module sigma_ram_sp
  import sigma_mem_responder_pkg::*;
#(
  parameter int    DEPTH_LOG2 = 7,
  parameter string INIT_FILE  = ""
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    we,
  input  logic [DEPTH_LOG2-1:0]   addr,
  input  logic [SIGMA_WORD_W-1:0] wdata,
  output logic [SIGMA_WORD_W-1:0] rdata
);
  logic [SIGMA_WORD_W-1:0] mem [2**DEPTH_LOG2];
  logic [SIGMA_WORD_W-1:0] dout_d, dout_q;
  initial begin
    for (int i = 0; i < 2**DEPTH_LOG2; i++) mem[i] = '0;
  end
  always_comb dout_d = (en && !we) ? mem[addr] : dout_q;
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
    dout_q <= dout_d;
  end
  assign rdata = dout_q;
endmodule

// File: rtl/sigma_mem_responder.sv
// sigma_mem_responder: req/ack RAM responder with wait states, range checking and transaction counters
module sigma_mem_responder
  import sigma_mem_responder_pkg::*;
#(
  parameter int    DEPTH_LOG2  = 7,
  parameter int    WAIT_STATES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req,
  input  logic         we,
  input  logic [15:31] address,
  input  logic [0:31]  wdata,
  output logic         ack,
  output logic [0:31]  rdata,
  output logic         err,
  output logic         busy,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
);
  localparam int CW = WAIT_STATES > 1 ? $clog2(WAIT_STATES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SIGMA_ADDR_W-1:0] addr_q, addr_d;
  logic [SIGMA_WORD_W-1:0] wdata_q, wdata_d, ram_dout;
  logic [15:0] rd_count_q, rd_count_d, wr_count_q, wr_count_d;
  logic we_q, we_d, oob_q, oob_d, ack_q, ack_d, err_q, err_d, busy_q, busy_d, rzero_q, rzero_d;
  logic commit;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    oob_d      = oob_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (state_q == ST_IDLE && req) begin
      addr_d  = address;
      wdata_d = wdata;
      we_d    = we;
      oob_d   = |addr_d[SIGMA_ADDR_W-1:DEPTH_LOG2];
      state_d = WAIT_STATES > 0 ? ST_WAIT : ST_ACK;
      cnt_d   = CNT_LOAD;
    end else if (state_q == ST_WAIT) begin
      cnt_d   = cnt_q - CW'(1);
      state_d = cnt_q == '0 ? ST_ACK : ST_WAIT;
    end else if (state_q == ST_ACK) begin
      state_d    = ST_IDLE;
      rd_count_d = rd_count_q + {15'd0, !we_q && rd_count_q != 16'hFFFF};
      wr_count_d = wr_count_q + {15'd0, we_q && wr_count_q != 16'hFFFF};
    end
    // Commit uses the _d copies so a zero-wait-state capture commits on the same edge
    commit  = state_d == ST_ACK && state_q != ST_ACK && !reset;
    ack_d   = state_d == ST_ACK;
    err_d   = ack_d && oob_d;
    busy_d  = state_d != ST_IDLE;
    rzero_d = (commit && !we_d) ? oob_d : rzero_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      oob_q      <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      rzero_q    <= 1'b1;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      oob_q      <= oob_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      rzero_q    <= rzero_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end
  sigma_ram_sp #(.DEPTH_LOG2(DEPTH_LOG2), .INIT_FILE(INIT_FILE)) u_ram (
    .clk  (clock),
    .en   (commit && !oob_d),
    .we   (we_d),
    .addr (addr_d[DEPTH_LOG2-1:0]),
    .wdata(wdata_d),
    .rdata(ram_dout)
  );
  assign ack      = ack_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign rdata    = rzero_q ? '0 : ram_dout;
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
endmodule
